// File: rtl/btn_debounce.sv
// Per-lane synchroniser + stability-counter debouncer with press/release strobes; optional hold-to-repeat.
// Latency: DB_CYCLES+2 cycles from raw edge to btn/strobe; no backpressure, strobes are fire-and-forget.
// Define BTN_DEBOUNCE_REPEAT_EN to build the repeat state machines; otherwise btn_repeat is tied to 0.
module btn_debounce #(
  parameter int NUM_BTN       = 8,
  parameter int DB_CYCLES     = 50000,
  parameter int CNT_W         = 16,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int REPEAT_DELAY  = 8000000,
  parameter int REPEAT_PERIOD = 2000000,
  parameter int RPT_W         = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  // Terminal compares must fit their counters, otherwise a count would wrap instead of firing.
  if (DB_CYCLES < 2 || 64'(DB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_db
    $error("btn_debounce: DB_CYCLES out of range for CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      64'(REPEAT_DELAY) >= (64'd1 << RPT_W) || 64'(REPEAT_PERIOD) >= (64'd1 << RPT_W)) begin : g_bad_rpt
    $error("btn_debounce: repeat timing out of range for RPT_W");
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_PERIOD
  } rpt_state_t;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    logic             s1;
    logic             s2;
    logic             lvl;
    logic             press_q;
    logic             rel_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             press_evt;
    logic             rel_evt;

    assign accept    = (s2 != lvl) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign press_evt = accept && s2;
    assign rel_evt   = accept && !s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        lvl     <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        cnt     <= '0;
      end else begin
        s1      <= btn_raw[i] ^ ACTIVE_LOW;
        s2      <= s1;
        press_q <= press_evt;
        rel_q   <= rel_evt;
        // Any sample matching the accepted level restarts the stability window.
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (accept) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign btn[i]         = lvl;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    rpt_state_t       st;
    logic [RPT_W-1:0] rc;
    logic             rpt_q;

    // Keys off the accept event rather than the registered strobe so the first
    // repeat lands exactly REPEAT_DELAY cycles after the press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= RPT_IDLE;
        rc    <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (press_evt) begin
          st <= RPT_DELAY;
          rc <= '0;
        end else if (rel_evt || !lvl) begin
          st <= RPT_IDLE;
          rc <= '0;
        end else begin
          case (st)
            RPT_DELAY: begin
              if (rc == RPT_W'(REPEAT_DELAY - 1)) begin
                rpt_q <= 1'b1;
                st    <= RPT_PERIOD;
                rc    <= '0;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            RPT_PERIOD: begin
              if (rc == RPT_W'(REPEAT_PERIOD - 1)) begin
                rpt_q <= 1'b1;
                rc    <= '0;
              end else begin
                rc <= rc + 1'b1;
              end
            end
            default: begin
              st <= RPT_IDLE;
              rc <= '0;
            end
          endcase
        end
      end
    end

    assign btn_repeat[i] = rpt_q;
`else
    assign btn_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn_raw;
  logic [7:0] btn;
  logic [7:0] btn_press;
  logic [7:0] btn_release;
  logic [7:0] btn_repeat;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .NUM_BTN      (8),
    .DB_CYCLES    (4),
    .CNT_W        (16),
    .ACTIVE_LOW   (1'b0),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5),
    .RPT_W        (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn        (btn),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 8'h00;
    repeat (3) tick();
    chk("rst_btn", btn, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    chk("rst_repeat", btn_repeat, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean press on lane 0: edge 1 is the first edge sampling the new level.
    btn_raw[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("clean_btn", btn[0], (e >= 6) ? 1 : 0);
      chk("clean_press", btn_press, (e == 6) ? 32'h01 : 0);
      chk("clean_release", btn_release, 0);
    end

    // Three-cycle low glitch must be rejected.
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) btn_raw[0] = 1'b1;
      chk("glitch_btn", btn[0], 1);
      chk("glitch_release", btn_release[0], 0);
    end

    // Sustained low releases on edge 6.
    btn_raw[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("rel_btn", btn[0], (e >= 6) ? 0 : 1);
      chk("rel_release", btn_release, (e == 6) ? 32'h01 : 0);
      chk("rel_press", btn_press, 0);
    end
    repeat (3) tick();

    // Hold lane 2: press at 6, repeats at 16,21,26,31 (if built); raw drops after edge 28,
    // release accepted at edge 34 and nothing repeats from then on.
    btn_raw[2] = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      chk("rpt_btn", btn[2], (e >= 6 && e < 34) ? 1 : 0);
      chk("rpt_press", btn_press, (e == 6) ? 32'h04 : 0);
      chk("rpt_release", btn_release, (e == 34) ? 32'h04 : 0);
`ifdef BTN_DEBOUNCE_REPEAT_EN
      chk("rpt_strobe", btn_repeat, (e >= 16 && e < 34 && (e - 16) % 5 == 0) ? 32'h04 : 0);
`else
      chk("rpt_strobe", btn_repeat, 0);
`endif
      if (e == 28) btn_raw[2] = 1'b0;
    end
    repeat (3) tick();

    // Bounce on lane 3: 1,0,1,0 for 2 cycles each, then hold 1.
    for (int k = 0; k < 4; k++) begin
      btn_raw[3] = (k % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) begin
        tick();
        chk("bounce_quiet_press", btn_press[3], 0);
        chk("bounce_quiet_btn", btn[3], 0);
      end
    end
    btn_raw[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("bounce_btn", btn[3], (e >= 6) ? 1 : 0);
      chk("bounce_press", btn_press, (e == 6) ? 32'h08 : 0);
    end

    // Lanes 1 and 5 together; lanes 0,2 stay low and lane 3 stays high.
    btn_raw[1] = 1'b1;
    btn_raw[5] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("multi_press", btn_press, (e == 6) ? 32'h22 : 0);
      chk("multi_btn", btn, (e >= 6) ? 32'h2A : 32'h08);
      chk("multi_release", btn_release, 0);
    end

    // Async reset mid-count on lane 7, asserted between edges.
    btn_raw[7] = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_btn", btn, 0);
    chk("arst_press", btn_press, 0);
    chk("arst_release", btn_release, 0);
    chk("arst_repeat", btn_repeat, 0);
    tick();
    chk("arst_hold_btn", btn, 0);
    #2;
    rst_n = 1'b1;
    // Held lanes 1,3,5,7 re-press together; reset never produces a release.
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("post_rst_press", btn_press, (e == 6) ? 32'hAA : 0);
      chk("post_rst_btn", btn, (e >= 6) ? 32'hAA : 0);
      chk("post_rst_release", btn_release, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
